// File: rtl/loop_gain_scheduler_if.sv
// Error stream and gain/status bundle between the phase detector, the gain scheduler and the loop filter.
// Defining LOOP_GAIN_SCHED_LOSS_CNT_EN adds the lock-loss counter output.
interface loop_gain_scheduler_if #(
    parameter int ERROR_WIDTH = 8,
    parameter int KP_WIDTH    = 3,
    parameter int KI_WIDTH    = 4
);
    logic                          enable_i;
    logic                          err_valid_i;
    logic signed [ERROR_WIDTH-1:0] error_i;
    logic [KP_WIDTH-1:0]           kp_o;
    logic [KI_WIDTH-1:0]           ki_o;
    logic                          gain_upd_o;
    logic                          locked_o;
    logic [1:0]                    state_o;
`ifdef LOOP_GAIN_SCHED_LOSS_CNT_EN
    logic [7:0]                    lock_loss_cnt_o;

    modport master (output enable_i, err_valid_i, error_i,
                    input  kp_o, ki_o, gain_upd_o, locked_o, state_o, lock_loss_cnt_o);
    modport slave  (input  enable_i, err_valid_i, error_i,
                    output kp_o, ki_o, gain_upd_o, locked_o, state_o, lock_loss_cnt_o);
`else
    modport master (output enable_i, err_valid_i, error_i,
                    input  kp_o, ki_o, gain_upd_o, locked_o, state_o);
    modport slave  (input  enable_i, err_valid_i, error_i,
                    output kp_o, ki_o, gain_upd_o, locked_o, state_o);
`endif
endinterface

// File: rtl/loop_gain_scheduler.sv
// Loop gain scheduler: steps DCO loop-filter gains ACQUIRE->TRACK->LOCKED from |error| run lengths.
// Latency: outputs registered, updated on the edge sampling the triggering sample; no backpressure.
// Optional LOOP_GAIN_SCHED_LOSS_CNT_EN adds a saturating LOCKED->ACQUIRE fallback counter.
module loop_gain_scheduler #(
    parameter int                  ERROR_WIDTH   = 8,
    parameter int                  KP_WIDTH      = 3,
    parameter int                  KI_WIDTH      = 4,
    parameter logic [KP_WIDTH-1:0] KP_ACQ        = 3'b100,
    parameter logic [KI_WIDTH-1:0] KI_ACQ        = 4'b0100,
    parameter logic [KP_WIDTH-1:0] KP_TRK        = 3'b010,
    parameter logic [KI_WIDTH-1:0] KI_TRK        = 4'b0010,
    parameter logic [KP_WIDTH-1:0] KP_LCK        = 3'b001,
    parameter logic [KI_WIDTH-1:0] KI_LCK        = 4'b0001,
    parameter int                  LOCK_THRESH   = 4,
    parameter int                  UNLOCK_THRESH = 16,
    parameter int                  LOCK_COUNT    = 16,
    parameter int                  UNLOCK_COUNT  = 4,
    parameter int                  CNT_WIDTH     = 8
) (
    input  logic                   gen_clk_i,
    input  logic                   reset_n_i,
    loop_gain_scheduler_if.slave   sif
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    localparam logic [31:0]          LOCK_TH     = LOCK_THRESH;
    localparam logic [31:0]          UNLOCK_TH   = UNLOCK_THRESH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;
    localparam logic [CNT_WIDTH-1:0] LOCK_LAST   = CNT_WIDTH'(LOCK_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0] UNLOCK_LAST = CNT_WIDTH'(UNLOCK_COUNT - 1);

    state_t                 state_q, state_d;
    logic [KP_WIDTH-1:0]    kp_q, kp_d;
    logic [KI_WIDTH-1:0]    ki_q, ki_d;
    logic                   gain_upd_q;
    logic                   locked_q;
    logic [CNT_WIDTH-1:0]   in_cnt, out_cnt;
    logic [ERROR_WIDTH-1:0] mag;
    logic                   in_win, out_win, advance, fallback;

    // Unsigned magnitude: the most negative code maps to 2^(W-1) rather than wrapping.
    assign mag      = sif.error_i[ERROR_WIDTH-1] ? (~sif.error_i + 1'b1) : sif.error_i;
    assign in_win   = 32'(mag) <= LOCK_TH;
    assign out_win  = 32'(mag) >  UNLOCK_TH;
    assign advance  = sif.err_valid_i && in_win  && (in_cnt  == LOCK_LAST);
    assign fallback = sif.err_valid_i && out_win && (out_cnt == UNLOCK_LAST);

    always_comb begin
        state_d = state_q;
        if (!sif.enable_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = ACQUIRE;
                ACQUIRE: if (advance) state_d = TRACK;
                TRACK: begin
                    if (fallback)     state_d = ACQUIRE;
                    else if (advance) state_d = LOCKED;
                end
                LOCKED:  if (fallback) state_d = ACQUIRE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        kp_d = KP_ACQ;
        ki_d = KI_ACQ;
        case (state_d)
            TRACK: begin
                kp_d = KP_TRK;
                ki_d = KI_TRK;
            end
            LOCKED: begin
                kp_d = KP_LCK;
                ki_d = KI_LCK;
            end
            default: ;
        endcase
    end

    // Gains and status are registered from the next state so they move on the same edge.
    always_ff @(posedge gen_clk_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            kp_q       <= KP_ACQ;
            ki_q       <= KI_ACQ;
            gain_upd_q <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            kp_q       <= kp_d;
            ki_q       <= ki_d;
            gain_upd_q <= (kp_d != kp_q) || (ki_d != ki_q);
            locked_q   <= (state_d == LOCKED);
        end
    end

    always_ff @(posedge gen_clk_i) begin
        if (!reset_n_i) begin
            in_cnt  <= '0;
            out_cnt <= '0;
        end else if ((state_d != state_q) || (state_q == IDLE)) begin
            in_cnt  <= '0;
            out_cnt <= '0;
        end else if (sif.err_valid_i) begin
            in_cnt  <= in_win  ? ((in_cnt  == CNT_MAX) ? in_cnt  : in_cnt  + 1'b1) : '0;
            out_cnt <= out_win ? ((out_cnt == CNT_MAX) ? out_cnt : out_cnt + 1'b1) : '0;
        end
    end

    assign sif.kp_o       = kp_q;
    assign sif.ki_o       = ki_q;
    assign sif.gain_upd_o = gain_upd_q;
    assign sif.locked_o   = locked_q;
    assign sif.state_o    = state_q;

`ifdef LOOP_GAIN_SCHED_LOSS_CNT_EN
    logic [7:0] loss_q;

    // Survives the IDLE transition; only reset clears it.
    always_ff @(posedge gen_clk_i) begin
        if (!reset_n_i) begin
            loss_q <= '0;
        end else if ((state_q == LOCKED) && (state_d == ACQUIRE) && (loss_q != 8'hFF)) begin
            loss_q <= loss_q + 1'b1;
        end
    end

    assign sif.lock_loss_cnt_o = loss_q;
`endif

endmodule

// File: tb/tb_loop_gain_scheduler.sv
// Directed bench for loop_gain_scheduler: stimulus pushes hand-derived per-edge expectations,
// a monitor pops one per edge and compares gains/status (and lock_loss_cnt_o when enabled).
module tb_loop_gain_scheduler;
    localparam logic [1:0] S_IDLE = 2'd0, S_ACQ = 2'd1, S_TRK = 2'd2, S_LCK = 2'd3;

    logic gen_clk_i = 1'b0;
    logic reset_n_i = 1'b0;

    loop_gain_scheduler_if #(.ERROR_WIDTH(8), .KP_WIDTH(3), .KI_WIDTH(4)) sif ();

    loop_gain_scheduler dut (
        .gen_clk_i (gen_clk_i),
        .reset_n_i (reset_n_i),
        .sif       (sif.slave)
    );

    always #5 gen_clk_i = ~gen_clk_i;

    typedef struct packed {
        logic [1:0] st;
        logic       upd;
        logic [7:0] loss;
    } exp_t;

    exp_t q[$];
    int   n_asrt = 0;
    int   n_fail = 0;
    logic [7:0] exp_loss = 8'd0;

    task automatic chk(input string nm, input int act, input int req);
        n_asrt++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: one expectation per edge, sampled 1 time unit after the rising edge.
    always @(posedge gen_clk_i) begin
        exp_t e;
        int   kp_x, ki_x;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            case (e.st)
                S_TRK:   begin kp_x = 2; ki_x = 2; end
                S_LCK:   begin kp_x = 1; ki_x = 1; end
                default: begin kp_x = 4; ki_x = 4; end
            endcase
            chk("state",    int'(sif.state_o),    int'(e.st));
            chk("kp",       int'(sif.kp_o),       kp_x);
            chk("ki",       int'(sif.ki_o),       ki_x);
            chk("locked",   int'(sif.locked_o),   (e.st == S_LCK) ? 1 : 0);
            chk("gain_upd", int'(sif.gain_upd_o), int'(e.upd));
`ifdef LOOP_GAIN_SCHED_LOSS_CNT_EN
            chk("lock_loss_cnt", int'(sif.lock_loss_cnt_o), int'(e.loss));
`endif
        end
    end

    task automatic step(input logic rn, input logic en, input logic vld,
                        input logic signed [7:0] err, input logic [1:0] st, input logic upd);
        exp_t e;
        @(negedge gen_clk_i);
        reset_n_i       = rn;
        sif.enable_i    = en;
        sif.err_valid_i = vld;
        sif.error_i     = err;
        if (!rn) exp_loss = 8'd0;
        e.st   = st;
        e.upd  = upd;
        e.loss = exp_loss;
        q.push_back(e);
        @(posedge gen_clk_i);
    endtask

    // From ACQUIRE with cleared counters: TRACK on the 16th in-window sample, LOCKED on the 32nd.
    task automatic climb(input int n, input logic signed [7:0] err);
        for (int i = 1; i <= n; i++) begin
            step(1, 1, 1, err, (i < 16) ? S_ACQ : (i < 32) ? S_TRK : S_LCK, (i == 16) || (i == 32));
        end
    endtask

    // From LOCKED: three out-of-window samples hold, the fourth falls back to ACQUIRE.
    task automatic unlock(input logic signed [7:0] err);
        for (int i = 1; i <= 3; i++) step(1, 1, 1, err, S_LCK, 0);
        exp_loss = (exp_loss == 8'hFF) ? exp_loss : exp_loss + 8'd1;
        step(1, 1, 1, err, S_ACQ, 1);
    endtask

    initial begin
        sif.enable_i    = 1'b0;
        sif.err_valid_i = 1'b0;
        sif.error_i     = '0;

        // Reset state.
        step(0, 0, 0, 8'sd0, S_IDLE, 0);
        step(0, 1, 1, 8'sd0, S_IDLE, 0);

        // Acquire to lock with error 2: ACQUIRE on edge 1, TRACK on 17, LOCKED on 33.
        step(1, 1, 1, 8'sd2, S_ACQ, 0);
        climb(32, 8'sd2);

        // Broken runs keep LOCKED: 10 is not out-of-window, nor is 16 (threshold edge).
        for (int i = 0; i < 3; i++) step(1, 1, 1, -8'sd20, S_LCK, 0);
        step(1, 1, 1, 8'sd10, S_LCK, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 1, -8'sd20, S_LCK, 0);
        step(1, 1, 1, 8'sd16, S_LCK, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 1, -8'sd20, S_LCK, 0);
        exp_loss = exp_loss + 8'd1;
        step(1, 1, 1, 8'sh80, S_ACQ, 1);

        // Run reset by a 5, and valid=0 gaps (with a large error) neither clear nor advance.
        for (int i = 0; i < 15; i++) begin
            step(1, 1, 1, 8'sd3, S_ACQ, 0);
            if (i == 7) step(1, 1, 0, 8'sd100, S_ACQ, 0);
        end
        step(1, 1, 1, 8'sd5, S_ACQ, 0);
        for (int i = 0; i < 15; i++) begin
            step(1, 1, 1, 8'sd3, S_ACQ, 0);
            if (i == 3 || i == 14) step(1, 1, 0, -8'sd90, S_ACQ, 0);
        end
        step(1, 1, 1, 8'sd3, S_TRK, 1);

        // Enable drop in TRACK: IDLE next edge with a single pulse; IDLE->ACQUIRE has none.
        step(1, 0, 1, 8'sd2, S_IDLE, 1);
        step(1, 0, 0, 8'sd0, S_IDLE, 0);
        step(1, 1, 1, 8'sd2, S_ACQ, 0);

        // Two more lock/unlock cycles (in-window boundary -4/4, out-of-window boundary -17).
        climb(32, -8'sd4);
        unlock(-8'sd17);
        climb(32, 8'sd4);
        unlock(8'sd17);

        // Loss count kept through an enable drop, cleared by a mid-run reset with enable held.
        step(1, 0, 1, 8'sd0, S_IDLE, 0);
        step(1, 1, 1, 8'sd0, S_ACQ, 0);
        climb(16, 8'sd0);
        step(0, 1, 1, 8'sd0, S_IDLE, 0);
        step(1, 1, 1, 8'sd0, S_ACQ, 0);

        @(posedge gen_clk_i);
        #3;
        chk("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
